ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
- Parametrised PS/2 keyboard receiver and scan-code decoder for the TennisGame input path.
- Samples the raw ps2c/ps2d lines, frames 11-bit packets with parity and stop checking, and recovers stalled frames with a watchdog.
- Folds E0/F0 prefixes into single make/break key events with an extended flag.
- Feeds game control logic directly; raw bytes are also exposed for host-command use.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- FILTER_LEN, 4, ps2c glitch-filter depth in clk samples (range 2..16).
- TIMEOUT_US, 200, maximum gap between ps2c falling edges inside a frame, in microseconds.
- CHECK_PARITY, 1, 1 = reject odd-parity failures; 0 = ignore the parity bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ps2c  in  1  raw PS/2 clock, asynchronous to clk.
- ps2d  in  1  raw PS/2 data, asynchronous to clk.
- byte_valid  out  1  one-cycle pulse when a good frame is received.
- byte_data  out  8  last good frame byte; held until the next good frame.
- key_valid  out  1  one-cycle pulse carrying a complete key event.
- key_code  out  8  scan code of the event; held between events.
- key_ext  out  1  event was preceded by E0.
- key_break  out  1  event was preceded by F0 (key release).
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset: every output, flag, counter and FSM state is 0/IDLE. Synchronisers and the filter are preset to 1 (idle bus).
- Input path:
  - ps2c and ps2d each pass through a 2-flop synchroniser.
  - Synchronised ps2c shifts into a FILTER_LEN register.
  - The filtered clock goes to 1 only when the register is all ones, to 0 only when it is all zeros, and otherwise holds.
  - fall = filtered clock 1 -> 0. Data is sampled from synchronised ps2d on the fall cycle.
- Frame FSM: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data 0 -> DATA, bit counter = 0. On fall with data 1: stay in IDLE, no error (stray edge).
  - DATA: on each fall, shift data in LSB-first. After the 8th bit -> PARITY.
  - PARITY: on fall, store the bit -> STOP.
  - STOP: on fall, evaluate the frame and go to IDLE.
    - Good frame: stop bit = 1 and (CHECK_PARITY=0 or data^parity has odd population count).
    - Good: byte_valid and byte_data update in the cycle after the stop-bit fall (latency 1 clk from the fall).
    - Otherwise: frame_err pulses at the same point, and byte_data keeps its previous value.
- Watchdog:
  - TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US. Counter width is clog2(TIMEOUT_CYC+1).
  - The counter clears on every fall and in IDLE, and increments in any other state.
  - When it reaches TIMEOUT_CYC: frame_err pulses, FSM -> IDLE, partial byte is discarded.
  - If a fall coincides with the timeout cycle, the fall wins and there is no error.
- Decoder (runs on byte_valid):
  - E0: set ext flag, no event.
  - F0: set brk flag, no event.
  - Any other byte: key_valid pulses 1 clk after byte_valid. key_code = byte, key_ext = ext, key_break = brk. Then both flags clear.
  - frame_err clears both flags; a broken prefix never leaks onto the next key.
  - Repeated E0 or F0 bytes are idempotent.
  - Total latency from stop-bit fall to key_valid is 2 clk.
- Asserting rst_n low mid-frame aborts the frame with no pulses. After release, the next valid frame decodes normally.
- key_ext and key_break are held with key_code between events.

Test Plan:
- Frame 0x1C (start 0, bits LSB-first, parity 0, stop 1) at 12.5 kHz -> byte_valid once with byte_data=0x1C; key_valid 1 clk later with code 0x1C, ext 0, break 0.
- Frames F0, 1C -> byte_valid twice; exactly one key_valid, code 0x1C, break 1, ext 0.
- Frames E0, F0, 74 -> one key_valid, code 0x74, ext 1, break 1. Then frame 74 -> ext 0, break 0.
- Frame F0 then 0x1C sent with parity 1 -> frame_err pulse, no byte_valid for 0x1C. Next good 0x1C reports break 0. Repeat with CHECK_PARITY=0 -> accepted as a break event.
- Stop ps2c after 5 data bits and hold high for more than 200 us -> single frame_err at TIMEOUT_CYC. The following good 0x29 frame decodes correctly.
- Pulse ps2c low for 2 clk (less than FILTER_LEN) in IDLE and mid-frame -> no bit shifted, frame unaffected.
- Assert rst_n low after 4 data bits -> all outputs 0. After release, a good 0x1C frame decodes correctly.

Source files
------------

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// Synchronises and glitch-filters the raw PS/2 lines. Frames 11-bit packets
// (start, 8 data bits LSB-first, odd parity, stop), with a watchdog that
// recovers stalled frames. E0/F0 prefixes are folded into single key events.
// Ports:
//   clk, rst_n     system clock / async active-low reset
//   ps2c, ps2d     raw PS/2 clock and data (asynchronous)
//   byte_valid     1-cycle pulse per good frame; byte_data holds the byte
//   key_valid      1-cycle pulse per key event; key_code/key_ext/key_break held
//   frame_err      1-cycle pulse on start/parity/stop/timeout error
module ps2_scan_decoder #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned TIMEOUT_US   = 200,
    parameter int unsigned CHECK_PARITY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       frame_err
);

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BIT_CNT_W   = 3;
    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BYTE_W-1:0] CODE_EXT = 8'hE0;
    localparam logic [BYTE_W-1:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic                  c_s1, c_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] filt;
    logic                  c_filt;
    logic                  fall_c;

    state_t                state, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [BYTE_W-1:0]     shreg, shreg_d;
    logic                  par, par_d;
    logic [WD_W-1:0]       wd_cnt;
    logic                  timeout_c;
    logic                  good_c;
    logic                  bad_c;

    logic                  ext_flag;
    logic                  brk_flag;

    // Input synchronisers and clock glitch filter; preset to idle-bus high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            filt   <= '1;
            c_filt <= 1'b1;
        end else begin
            c_s1 <= ps2c;
            c_s2 <= c_s1;
            d_s1 <= ps2d;
            d_s2 <= d_s1;
            filt <= {filt[FILTER_LEN-2:0], c_s2};
            if (filt == '1) begin
                c_filt <= 1'b1;
            end else if (filt == '0) begin
                c_filt <= 1'b0;
            end
        end
    end

    // Filtered clock is about to fall this cycle
    assign fall_c = c_filt && (filt == '0);

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            par     <= par_d;
        end
    end

    // Frame FSM next state; a fall in the timeout cycle takes priority
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        par_d     = par;
        good_c    = 1'b0;
        bad_c     = 1'b0;
        timeout_c = (state != IDLE) && !fall_c && (wd_cnt == WD_W'(TIMEOUT_CYC));
        if (timeout_c) begin
            state_d = IDLE;
            bad_c   = 1'b1;
        end else if (fall_c) begin
            case (state)
                IDLE: begin
                    if (!d_s2) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d   = {d_s2, shreg[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = d_s2;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (d_s2 && ((CHECK_PARITY == 0) || (^{shreg, par}))) begin
                        good_c = 1'b1;
                    end else begin
                        bad_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Watchdog: counts clk cycles since the last fall while inside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (fall_c || (state == IDLE) || timeout_c) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Byte-level outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= good_c;
            frame_err  <= bad_c;
            if (good_c) begin
                byte_data <= shreg;
            end
        end
    end

    // Prefix folding; any frame error drops pending prefixes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == CODE_EXT) begin
                    ext_flag <= 1'b1;
                end else if (byte_data == CODE_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= byte_data;
                    key_ext   <= ext_flag;
                    key_break <= brk_flag;
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder. Two instances share the PS/2 lines:
// one with parity checking, one without. Clock rate parameter is 1 MHz so
// one clk = 1 us: PS/2 bit period 80 clk (12.5 kHz), timeout 200 clk.
module tb_ps2_scan_decoder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c  = 1'b1;
    logic       ps2d  = 1'b1;

    logic       byte_valid, key_valid, key_ext, key_break, frame_err;
    logic [7:0] byte_data, key_code;
    logic       np_byte_valid, np_key_valid, np_key_ext, np_key_break, np_frame_err;
    logic [7:0] np_byte_data, np_key_code;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int bv_cnt = 0, kv_cnt = 0, err_cnt = 0, np_kv_cnt = 0, np_err_cnt = 0;
    int bv_cyc = 0, kv_cyc = 0, err_cyc = 0, fall_drive_cyc = 0;
    int b0, k0, e0, nk0, ne0;

    ps2_scan_decoder #(
        .CLK_HZ(1000000), .FILTER_LEN(4), .TIMEOUT_US(200), .CHECK_PARITY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .frame_err(frame_err)
    );

    ps2_scan_decoder #(
        .CLK_HZ(1000000), .FILTER_LEN(4), .TIMEOUT_US(200), .CHECK_PARITY(0)
    ) dut_np (
        .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d),
        .byte_valid(np_byte_valid), .byte_data(np_byte_data),
        .key_valid(np_key_valid), .key_code(np_key_code),
        .key_ext(np_key_ext), .key_break(np_key_break), .frame_err(np_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (byte_valid) begin bv_cnt++; bv_cyc = cyc; end
        if (key_valid) begin kv_cnt++; kv_cyc = cyc; end
        if (frame_err) begin err_cnt++; err_cyc = cyc; end
        if (np_key_valid) np_kv_cnt++;
        if (np_frame_err) np_err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b0 = bv_cnt; k0 = kv_cnt; e0 = err_cnt; nk0 = np_kv_cnt; ne0 = np_err_cnt;
    endtask

    // Drive the first nbits of a frame; optional 2-clk ps2c glitch in the
    // high phase before bit glitch_bit's falling edge
    task automatic send_frame(input logic [7:0] data, input logic bad_par,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            if (glitch_bit == i) begin
                tick(10); ps2c = 1'b0; tick(2); ps2c = 1'b1; tick(8);
            end else begin
                tick(20);
            end
            ps2c = 1'b0;
            fall_drive_cyc = cyc;
            tick(40);
            ps2c = 1'b1;
            tick(20);
        end
        ps2d = 1'b1;
        tick(100);
    endtask

    initial begin
        // Reset state
        tick(5);
        check("reset_outputs", 32'({byte_valid, byte_data, key_valid, key_code,
                                    key_ext, key_break, frame_err}), 32'h0);
        rst_n = 1'b1;
        tick(20);
        check("idle_no_pulses", 32'(bv_cnt + kv_cnt + err_cnt), 32'd0);

        // Single make code
        snap();
        send_frame(8'h1C, 1'b0, 11, -1);
        check("mk_bv_count", 32'(bv_cnt - b0), 32'd1);
        check("mk_byte_data", 32'(byte_data), 32'h1C);
        check("mk_kv_count", 32'(kv_cnt - k0), 32'd1);
        check("mk_key", 32'({key_code, key_ext, key_break}), 32'({8'h1C, 1'b0, 1'b0}));
        check("mk_latency", 32'(kv_cyc - bv_cyc), 32'd1);
        check("mk_no_err", 32'(err_cnt - e0), 32'd0);

        // Break code
        snap();
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b0, 11, -1);
        check("brk_bv_count", 32'(bv_cnt - b0), 32'd2);
        check("brk_kv_count", 32'(kv_cnt - k0), 32'd1);
        check("brk_key", 32'({key_code, key_ext, key_break}), 32'({8'h1C, 1'b0, 1'b1}));

        // Extended break, then plain make of the same code
        snap();
        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h74, 1'b0, 11, -1);
        check("ext_kv_count", 32'(kv_cnt - k0), 32'd1);
        check("ext_key", 32'({key_code, key_ext, key_break}), 32'({8'h74, 1'b1, 1'b1}));
        send_frame(8'h74, 1'b0, 11, -1);
        check("ext_after_key", 32'({key_code, key_ext, key_break}), 32'({8'h74, 1'b0, 1'b0}));

        // Parity error after F0 drops the prefix; no-parity instance accepts it
        snap();
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b1, 11, -1);
        check("par_err_count", 32'(err_cnt - e0), 32'd1);
        check("par_bv_count", 32'(bv_cnt - b0), 32'd1);
        check("par_byte_held", 32'(byte_data), 32'hF0);
        check("par_kv_count", 32'(kv_cnt - k0), 32'd0);
        check("np_par_kv_count", 32'(np_kv_cnt - nk0), 32'd1);
        check("np_par_err_count", 32'(np_err_cnt - ne0), 32'd0);
        check("np_par_key", 32'({np_key_code, np_key_ext, np_key_break}), 32'({8'h1C, 1'b0, 1'b1}));
        send_frame(8'h1C, 1'b0, 11, -1);
        check("par_next_key", 32'({key_code, key_ext, key_break}), 32'({8'h1C, 1'b0, 1'b0}));
        check("np_par_next_key", 32'({np_key_code, np_key_ext, np_key_break}), 32'({8'h1C, 1'b0, 1'b0}));

        // Watchdog: F0, then a frame stalled after 5 data bits, then 0x29
        snap();
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'hFF, 1'b0, 6, -1);
        tick(300);
        check("to_err_count", 32'(err_cnt - e0), 32'd1);
        // 2 sync + 4 filter + 1 fall register + 200 timeout + 1 output register
        check("to_err_timing", 32'(err_cyc - fall_drive_cyc), 32'd208);
        check("to_no_byte", 32'(bv_cnt - b0), 32'd1);
        check("np_to_err_count", 32'(np_err_cnt - ne0), 32'd1);
        send_frame(8'h29, 1'b0, 11, -1);
        check("to_next_key", 32'({key_code, key_ext, key_break}), 32'({8'h29, 1'b0, 1'b0}));
        check("to_next_kv", 32'(kv_cnt - k0), 32'd1);

        // Short ps2c glitches in idle and mid-frame are ignored
        snap();
        ps2c = 1'b0; tick(2); ps2c = 1'b1; tick(50);
        check("gl_idle_quiet", 32'((bv_cnt - b0) + (err_cnt - e0)), 32'd0);
        send_frame(8'h1C, 1'b0, 11, 3);
        check("gl_bv_count", 32'(bv_cnt - b0), 32'd1);
        check("gl_byte_data", 32'(byte_data), 32'h1C);
        check("gl_no_err", 32'(err_cnt - e0), 32'd0);

        // Reset mid-frame
        snap();
        send_frame(8'h55, 1'b0, 5, -1);
        rst_n = 1'b0;
        tick(5);
        check("rst_outputs", 32'({byte_valid, byte_data, key_valid, key_code,
                                  key_ext, key_break, frame_err}), 32'h0);
        rst_n = 1'b1;
        tick(50);
        send_frame(8'h1C, 1'b0, 11, -1);
        check("rst_no_err", 32'(err_cnt - e0), 32'd0);
        check("rst_bv_count", 32'(bv_cnt - b0), 32'd1);
        check("rst_key", 32'({byte_data, key_code, key_ext, key_break}),
              32'({8'h1C, 8'h1C, 1'b0, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
